hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Producer side of the pipeline forwarding protocol. Decodes the D-stage instruction into destination register, Tnew and Tuse. Carries destination/Tnew through E, M and W scoreboard registers, and drives reg_addr_M, reg_addr_W and Tnew_M to the E-stage control unit. Also generates the D-stage stall (freeze F/D, bubble into E) and the D-stage forwarding selects.

Parameters:
TW, 2, width of Tnew/Tuse fields
AW, 5, register address width

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high
instr_D  input  32  instruction currently in D stage
stall  output  1  1 = hold PC and F/D register, insert bubble into E
reg_addr_E  output  5  destination of instruction in E (0 = none)
Tnew_E  output  2  cycles until E's result exists
reg_addr_M  output  5  destination of instruction in M
Tnew_M  output  2  cycles until M's result exists (0 = forwardable from M)
reg_addr_W  output  5  destination of instruction in W
fwd_rs_D_op  output  2  D-stage rs source: 3 = E, 2 = M, 1 = W, 0 = GRF
fwd_rt_D_op  output  2  D-stage rt source, same encoding

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high.
- Reset: all scoreboard registers (reg_addr_E/M/W, Tnew_E/M) are 0 on the first edge with reset=1. stall and fwd ops are combinational from that state, so they are 0 after reset.
- Decode of instr_D uses op = [31:26], func = [5:0]; R = op 0.
  - cal_r: add, sub, and, or, slt, sltu, sll. Destination rd, Tnew 1, Tuse rs = 1, Tuse rt = 1.
  - cal_i: ori, lui, addi, andi. Destination rt, Tnew 1, Tuse rs = 1 (lui has no rs use).
  - load: lw, lb, lh. Destination rt, Tnew 2, Tuse rs = 1.
  - store: sw, sb, sh. No destination, Tuse rs = 1, Tuse rt = 2.
  - beq, bne: Tuse rs = rt = 0. jr: Tuse rs = 0.
  - jal: destination 31, Tnew 0 (PC+8 available at E).
  - Anything else: no destination, no uses.
  - sll uses rt only.
- Stall, combinational, for src in {rs, rt} with a use:
  - stall when src != 0 and src == reg_addr_E and Tnew_E > Tuse_src, or
  - src != 0 and src == reg_addr_M and Tnew_M > Tuse_src.
  - W never causes a stall.
- Forward select, per src with src != 0, first match wins:
  - src == reg_addr_E and Tnew_E == 0 gives 3;
  - src == reg_addr_M and Tnew_M == 0 gives 2;
  - src == reg_addr_W gives 1;
  - else 0.
  - A match in E with Tnew_E > 0 blocks lower-priority sources (result 0; stall covers it).
- Clock edge, reset=0:
  - reg_addr_W <= reg_addr_M.
  - reg_addr_M <= reg_addr_E, Tnew_M <= sat_dec(Tnew_E).
  - If stall: reg_addr_E <= 0, Tnew_E <= 0 (bubble). Else reg_addr_E/Tnew_E <= decoded values of instr_D.
  - sat_dec(x) = x == 0 ? 0 : x - 1. Tnew is never negative.
- Latency: a load entering E with Tnew 2 reaches M with Tnew 1 and W with 0. A dependent branch stalls 2 cycles; a dependent cal stalls 1 cycle.
- Destination 0 is always treated as "no write"; it never matches, stalls or forwards.
- Reset mid-stall: reset wins. Scoreboard clears and the following cycle has no stall.

Decomposition:
- Shared package holds:
  - opcode/func constants (op/func values above);
  - Tnew/Tuse constants (T0, T1, T2);
  - forward-select encodings (FWD_GRF=0, FWD_W=1, FWD_M=2, FWD_E=3).
- One natural sub-module: hazard_decode (combinational instr -> dest, Tnew, Tuse_rs, Tuse_rt, use_rs, use_rt). It is reusable by the E-stage control unit.

Test Plan:
- Reset held 1 cycle, then instr_D = nop -> reg_addr_E/M/W = 0, Tnew_E = Tnew_M = 0, stall = 0, fwd ops 0.
- lw $8,0($0) then beq $8,$9 -> stall = 1 for 2 cycles (Tnew_E = 2 then Tnew_M = 1); third cycle stall = 0, fwd_rs_D_op = 1.
- addi $5,$0,1 then addu-class add $6,$5,$5 -> no stall; in E, reg_addr_E = 5, Tnew_E = 1; next cycle, after moving to M, Tnew_M = 0 and reg_addr_M = 5.
- lw $3 then sw $3,4($0) (rt use, Tuse 2) -> no stall; sw in E sees reg_addr_M = 3, Tnew_M = 1.
- jal then jr $31 -> Tnew_E = 0, reg_addr_E = 31, no stall, fwd_rs_D_op = 3.
- Write to $0 (ori $0,$0,5) followed by beq $0,$0 -> reg_addr_E = 0, stall = 0, fwd ops 0; reset asserted during a load stall -> next cycle stall = 0, scoreboard 0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the D-stage hazard unit and its instruction decoder.
// Opcode/func values, Tnew/Tuse constants, forward-select codes and the instruction classifier.
package hazard_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_JR   = 6'h08;
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_SLT  = 6'h2a;
    localparam logic [5:0] FUNC_SLTU = 6'h2b;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_W   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_E   = 2'd3;

    localparam int unsigned REG_RA = 31;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_CAL_R,
        CLS_SHIFT,
        CLS_CAL_I,
        CLS_LUI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JR,
        CLS_JAL
    } instr_class_e;

    function automatic instr_class_e classify(input logic [5:0] op, input logic [5:0] func);
        instr_class_e cls;
        cls = CLS_NONE;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR,
                    FUNC_SLT, FUNC_SLTU:  cls = CLS_CAL_R;
                    FUNC_SLL:             cls = CLS_SHIFT;
                    FUNC_JR:              cls = CLS_JR;
                    default:              cls = CLS_NONE;
                endcase
            end
            OP_ORI, OP_ADDI, OP_ANDI:     cls = CLS_CAL_I;
            OP_LUI:                       cls = CLS_LUI;
            OP_LW, OP_LB, OP_LH:          cls = CLS_LOAD;
            OP_SW, OP_SB, OP_SH:          cls = CLS_STORE;
            OP_BEQ, OP_BNE:               cls = CLS_BRANCH;
            OP_JAL:                       cls = CLS_JAL;
            default:                      cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of one instruction into destination, Tnew and per-source Tuse.
// Shared with the E-stage control unit so both sides agree on timing.
module hazard_decode
    import hazard_unit_pkg::*;
#(
    parameter int unsigned TW = 2,
    parameter int unsigned AW = 5
) (
    input  logic [31:0]   instr,
    output logic [AW-1:0] dest,
    output logic [TW-1:0] tnew,
    output logic [TW-1:0] tuse_rs,
    output logic [TW-1:0] tuse_rt,
    output logic          use_rs,
    output logic          use_rt
);

    instr_class_e cls;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic unused_shamt;

    assign rt = AW'(instr[20:16]);
    assign rd = AW'(instr[15:11]);
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        cls     = classify(instr[31:26], instr[5:0]);
        dest    = '0;
        tnew    = '0;
        tuse_rs = '0;
        tuse_rt = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        case (cls)
            CLS_CAL_R: begin
                dest    = rd;
                tnew    = TW'(T1);
                use_rs  = 1'b1;
                tuse_rs = TW'(T1);
                use_rt  = 1'b1;
                tuse_rt = TW'(T1);
            end
            // sll shifts rt; its rs field carries no operand
            CLS_SHIFT: begin
                dest    = rd;
                tnew    = TW'(T1);
                use_rt  = 1'b1;
                tuse_rt = TW'(T1);
            end
            CLS_CAL_I: begin
                dest    = rt;
                tnew    = TW'(T1);
                use_rs  = 1'b1;
                tuse_rs = TW'(T1);
            end
            CLS_LUI: begin
                dest    = rt;
                tnew    = TW'(T1);
            end
            CLS_LOAD: begin
                dest    = rt;
                tnew    = TW'(T2);
                use_rs  = 1'b1;
                tuse_rs = TW'(T1);
            end
            CLS_STORE: begin
                use_rs  = 1'b1;
                tuse_rs = TW'(T1);
                use_rt  = 1'b1;
                tuse_rt = TW'(T2);
            end
            CLS_BRANCH: begin
                use_rs  = 1'b1;
                tuse_rs = TW'(T0);
                use_rt  = 1'b1;
                tuse_rt = TW'(T0);
            end
            CLS_JR: begin
                use_rs  = 1'b1;
                tuse_rs = TW'(T0);
            end
            CLS_JAL: begin
                dest    = AW'(REG_RA);
                tnew    = TW'(T0);
            end
            default: begin
                dest    = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// D-stage hazard unit: E/M/W destination scoreboard, stall generation and D-stage forward selects.
// Register 0 is never a producer, so it never matches, stalls or forwards.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned TW = 2,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr_D,
    output logic          stall,
    output logic [AW-1:0] reg_addr_E,
    output logic [TW-1:0] Tnew_E,
    output logic [AW-1:0] reg_addr_M,
    output logic [TW-1:0] Tnew_M,
    output logic [AW-1:0] reg_addr_W,
    output logic [1:0]    fwd_rs_D_op,
    output logic [1:0]    fwd_rt_D_op
);

    logic [AW-1:0] rs_D;
    logic [AW-1:0] rt_D;
    logic [AW-1:0] dest_D;
    logic [TW-1:0] tnew_D;
    logic [TW-1:0] tuse_rs_D;
    logic [TW-1:0] tuse_rt_D;
    logic          use_rs_D;
    logic          use_rt_D;
    logic          stall_rs;
    logic          stall_rt;

    assign rs_D = AW'(instr_D[25:21]);
    assign rt_D = AW'(instr_D[20:16]);

    hazard_decode #(
        .TW(TW),
        .AW(AW)
    ) u_decode (
        .instr   (instr_D),
        .dest    (dest_D),
        .tnew    (tnew_D),
        .tuse_rs (tuse_rs_D),
        .tuse_rt (tuse_rt_D),
        .use_rs  (use_rs_D),
        .use_rt  (use_rt_D)
    );

    function automatic logic src_stall(
        input logic [AW-1:0] src,
        input logic [TW-1:0] tuse,
        input logic [AW-1:0] addr_e,
        input logic [TW-1:0] tnew_e,
        input logic [AW-1:0] addr_m,
        input logic [TW-1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src != '0) && (src == addr_e) && (tnew_e > tuse);
        hit_m = (src != '0) && (src == addr_m) && (tnew_m > tuse);
        return hit_e || hit_m;
    endfunction

    // A pending E result shadows older copies in M/W; the stall covers that case
    function automatic logic [1:0] fwd_select(
        input logic [AW-1:0] src,
        input logic [AW-1:0] addr_e,
        input logic [TW-1:0] tnew_e,
        input logic [AW-1:0] addr_m,
        input logic [TW-1:0] tnew_m,
        input logic [AW-1:0] addr_w
    );
        logic [1:0] sel;
        sel = FWD_GRF;
        if (src == '0) begin
            sel = FWD_GRF;
        end else if (src == addr_e) begin
            sel = (tnew_e == '0) ? FWD_E : FWD_GRF;
        end else if ((src == addr_m) && (tnew_m == '0)) begin
            sel = FWD_M;
        end else if (src == addr_w) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    always_comb begin
        stall_rs    = use_rs_D && src_stall(rs_D, tuse_rs_D, reg_addr_E, Tnew_E, reg_addr_M, Tnew_M);
        stall_rt    = use_rt_D && src_stall(rt_D, tuse_rt_D, reg_addr_E, Tnew_E, reg_addr_M, Tnew_M);
        stall       = stall_rs || stall_rt;
        fwd_rs_D_op = fwd_select(rs_D, reg_addr_E, Tnew_E, reg_addr_M, Tnew_M, reg_addr_W);
        fwd_rt_D_op = fwd_select(rt_D, reg_addr_E, Tnew_E, reg_addr_M, Tnew_M, reg_addr_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_addr_E <= '0;
            Tnew_E     <= '0;
            reg_addr_M <= '0;
            Tnew_M     <= '0;
            reg_addr_W <= '0;
        end else begin
            reg_addr_W <= reg_addr_M;
            reg_addr_M <= reg_addr_E;
            Tnew_M     <= sat_dec(Tnew_E);
            if (stall) begin
                reg_addr_E <= '0;
                Tnew_E     <= '0;
            end else begin
                reg_addr_E <= dest_D;
                Tnew_E     <= tnew_D;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
// Each scenario task drives D-stage instructions and checks scoreboard, stall and forward selects.
module tb_hazard_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr_D;
    logic        stall;
    logic [4:0]  reg_addr_E;
    logic [1:0]  Tnew_E;
    logic [4:0]  reg_addr_M;
    logic [1:0]  Tnew_M;
    logic [4:0]  reg_addr_W;
    logic [1:0]  fwd_rs_D_op;
    logic [1:0]  fwd_rt_D_op;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    hazard_unit #(
        .TW(2),
        .AW(5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_D     (instr_D),
        .stall       (stall),
        .reg_addr_E  (reg_addr_E),
        .Tnew_E      (Tnew_E),
        .reg_addr_M  (reg_addr_M),
        .Tnew_M      (Tnew_M),
        .reg_addr_W  (reg_addr_W),
        .fwd_rs_D_op (fwd_rs_D_op),
        .fwd_rt_D_op (fwd_rt_D_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] func);
        return {6'h00, rs, rt, rd, sh, func};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        instr_D = NOP;
        tick();
        reset   = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (reg_addr_E !== 5'd0) begin errors++; $display("FAIL rst_addr_E: got %0d expected 0", reg_addr_E); end
        checks++; if (reg_addr_M !== 5'd0) begin errors++; $display("FAIL rst_addr_M: got %0d expected 0", reg_addr_M); end
        checks++; if (reg_addr_W !== 5'd0) begin errors++; $display("FAIL rst_addr_W: got %0d expected 0", reg_addr_W); end
        checks++; if (Tnew_E !== 2'd0) begin errors++; $display("FAIL rst_tnew_E: got %0d expected 0", Tnew_E); end
        checks++; if (Tnew_M !== 2'd0) begin errors++; $display("FAIL rst_tnew_M: got %0d expected 0", Tnew_M); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b expected 0", stall); end
        checks++; if (fwd_rs_D_op !== 2'd0 || fwd_rt_D_op !== 2'd0) begin
            errors++; $display("FAIL rst_fwd: got rs=%0d rt=%0d expected 0 0", fwd_rs_D_op, fwd_rt_D_op);
        end
    endtask

    // lw $8,0($0) ; beq $8,$9 -> two stall cycles then W forward
    task automatic test_load_branch();
        apply_reset();
        instr_D = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_lw_stall: got %0b expected 0", stall); end
        tick();
        instr_D = enc_i(6'h04, 5'd8, 5'd9, 16'd0);
        #1;
        checks++; if (reg_addr_E !== 5'd8 || Tnew_E !== 2'd2) begin
            errors++; $display("FAIL lb_E: got addr=%0d tnew=%0d expected 8 2", reg_addr_E, Tnew_E);
        end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall1: got %0b expected 1", stall); end
        tick();
        checks++; if (reg_addr_M !== 5'd8 || Tnew_M !== 2'd1) begin
            errors++; $display("FAIL lb_M: got addr=%0d tnew=%0d expected 8 1", reg_addr_M, Tnew_M);
        end
        checks++; if (reg_addr_E !== 5'd0 || Tnew_E !== 2'd0) begin
            errors++; $display("FAIL lb_bubble: got addr=%0d tnew=%0d expected 0 0", reg_addr_E, Tnew_E);
        end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall2: got %0b expected 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lb_stall3: got %0b expected 0", stall); end
        checks++; if (reg_addr_W !== 5'd8) begin errors++; $display("FAIL lb_W: got %0d expected 8", reg_addr_W); end
        checks++; if (fwd_rs_D_op !== 2'd1) begin errors++; $display("FAIL lb_fwd_rs: got %0d expected 1", fwd_rs_D_op); end
        checks++; if (fwd_rt_D_op !== 2'd0) begin errors++; $display("FAIL lb_fwd_rt: got %0d expected 0", fwd_rt_D_op); end
    endtask

    // addi $5,$0,1 ; add $6,$5,$5 ; or $7,$5,$0
    task automatic test_cal_chain();
        apply_reset();
        instr_D = enc_i(6'h08, 5'd0, 5'd5, 16'd1);
        tick();
        instr_D = enc_r(5'd5, 5'd5, 5'd6, 5'd0, 6'h20);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cal_stall: got %0b expected 0", stall); end
        checks++; if (reg_addr_E !== 5'd5 || Tnew_E !== 2'd1) begin
            errors++; $display("FAIL cal_E: got addr=%0d tnew=%0d expected 5 1", reg_addr_E, Tnew_E);
        end
        checks++; if (fwd_rs_D_op !== 2'd0) begin errors++; $display("FAIL cal_fwd_blocked: got %0d expected 0", fwd_rs_D_op); end
        tick();
        instr_D = enc_r(5'd5, 5'd0, 5'd7, 5'd0, 6'h25);
        #1;
        checks++; if (reg_addr_M !== 5'd5 || Tnew_M !== 2'd0) begin
            errors++; $display("FAIL cal_M: got addr=%0d tnew=%0d expected 5 0", reg_addr_M, Tnew_M);
        end
        checks++; if (reg_addr_E !== 5'd6 || Tnew_E !== 2'd1) begin
            errors++; $display("FAIL cal_E2: got addr=%0d tnew=%0d expected 6 1", reg_addr_E, Tnew_E);
        end
        checks++; if (fwd_rs_D_op !== 2'd2 || stall !== 1'b0) begin
            errors++; $display("FAIL cal_fwd_M: got fwd=%0d stall=%0b expected 2 0", fwd_rs_D_op, stall);
        end
    endtask

    // lw $3,0($0) ; sw $3,4($0): store data use is late enough to avoid a stall
    task automatic test_load_store();
        apply_reset();
        instr_D = enc_i(6'h23, 5'd0, 5'd3, 16'd0);
        tick();
        instr_D = enc_i(6'h2b, 5'd0, 5'd3, 16'd4);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ls_stall: got %0b expected 0", stall); end
        tick();
        instr_D = NOP;
        #1;
        checks++; if (reg_addr_M !== 5'd3 || Tnew_M !== 2'd1) begin
            errors++; $display("FAIL ls_M: got addr=%0d tnew=%0d expected 3 1", reg_addr_M, Tnew_M);
        end
        checks++; if (reg_addr_E !== 5'd0 || Tnew_E !== 2'd0) begin
            errors++; $display("FAIL ls_sw_E: got addr=%0d tnew=%0d expected 0 0", reg_addr_E, Tnew_E);
        end
    endtask

    // jal ; jr $31 -> link register forwarded straight from E
    task automatic test_jal_jr();
        apply_reset();
        instr_D = {6'h03, 26'h000_0100};
        tick();
        instr_D = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        #1;
        checks++; if (reg_addr_E !== 5'd31 || Tnew_E !== 2'd0) begin
            errors++; $display("FAIL jal_E: got addr=%0d tnew=%0d expected 31 0", reg_addr_E, Tnew_E);
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jr_stall: got %0b expected 0", stall); end
        checks++; if (fwd_rs_D_op !== 2'd3) begin errors++; $display("FAIL jr_fwd: got %0d expected 3", fwd_rs_D_op); end
    endtask

    // ori $0,$0,5 ; beq $0,$0 -> register 0 never participates
    task automatic test_zero_reg();
        apply_reset();
        instr_D = enc_i(6'h0d, 5'd0, 5'd0, 16'd5);
        tick();
        instr_D = enc_i(6'h04, 5'd0, 5'd0, 16'd0);
        #1;
        checks++; if (reg_addr_E !== 5'd0) begin errors++; $display("FAIL zero_E: got %0d expected 0", reg_addr_E); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %0b expected 0", stall); end
        checks++; if (fwd_rs_D_op !== 2'd0 || fwd_rt_D_op !== 2'd0) begin
            errors++; $display("FAIL zero_fwd: got rs=%0d rt=%0d expected 0 0", fwd_rs_D_op, fwd_rt_D_op);
        end
    endtask

    // load followed by sll/lui/add consumers: use-field sensitivity and one-cycle cal stall
    task automatic test_back_to_back();
        apply_reset();
        instr_D = enc_i(6'h23, 5'd0, 5'd10, 16'd0);
        tick();
        instr_D = enc_r(5'd10, 5'd0, 5'd12, 5'd2, 6'h00);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sll_rs_ignored: got %0b expected 0", stall); end
        instr_D = enc_i(6'h0f, 5'd10, 5'd13, 16'h1234);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lui_no_rs: got %0b expected 0", stall); end
        instr_D = enc_r(5'd0, 5'd10, 5'd12, 5'd2, 6'h00);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sll_rt_stall: got %0b expected 1", stall); end
        instr_D = enc_r(5'd10, 5'd0, 5'd11, 5'd0, 6'h20);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL add_stall1: got %0b expected 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall2: got %0b expected 0", stall); end
        checks++; if (Tnew_M !== 2'd1 || reg_addr_E !== 5'd0) begin
            errors++; $display("FAIL add_pipe: got tnew_M=%0d addr_E=%0d expected 1 0", Tnew_M, reg_addr_E);
        end
        tick();
        instr_D = NOP;
        #1;
        checks++; if (reg_addr_E !== 5'd11 || Tnew_E !== 2'd1 || reg_addr_W !== 5'd10) begin
            errors++; $display("FAIL add_issue: got addr_E=%0d tnew_E=%0d addr_W=%0d expected 11 1 10",
                               reg_addr_E, Tnew_E, reg_addr_W);
        end
    endtask

    // reset asserted while a load-use stall is active
    task automatic test_reset_mid_stall();
        apply_reset();
        instr_D = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
        tick();
        instr_D = enc_i(6'h05, 5'd8, 5'd9, 16'd0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_pre: got %0b expected 1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall: got %0b expected 0", stall); end
        checks++; if (reg_addr_E !== 5'd0 || reg_addr_M !== 5'd0 || reg_addr_W !== 5'd0 ||
                      Tnew_E !== 2'd0 || Tnew_M !== 2'd0) begin
            errors++; $display("FAIL rms_sb: got E=%0d/%0d M=%0d/%0d W=%0d expected all 0",
                               reg_addr_E, Tnew_E, reg_addr_M, Tnew_M, reg_addr_W);
        end
    endtask

    initial begin
        reset   = 1'b1;
        instr_D = NOP;
        test_reset();
        test_load_branch();
        test_cal_chain();
        test_load_store();
        test_jal_jr();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
